conv_maxpool: RTL and testbench
===============================

# conv_maxpool

Second stage of the CONV accelerator datapath. It reads the layer-0 map, the 64x64 grid of 20-bit results written by the convolution/ReLU stage with csel=3'b001. It performs 2x2, stride-2 max-pooling and writes the 32x32 result to layer-1 memory with csel=3'b011. It uses the same busy/ready handshake and the same shared layer-memory port (crd/caddr_rd/cdata_rd, cwr/caddr_wr/cdata_wr, csel) as the convolution stage, so the top level can run the two stages back to back.

## Interface
- DW, 20, data width of layer-memory words (signed, Q4.16 fixed point)
- RD_SEL, 3'b001, csel value driven during read cycles (layer-0 memory)
- WR_SEL, 3'b011, csel value driven during write cycles (layer-1 memory)
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- ready  input  1  start request; sampled only while idle
- busy  output  1  high from start until the last write completes
- crd  output  1  read strobe to layer memory
- caddr_rd  output  12  read address = row*64 + col, i.e. {row[5:0], col[5:0]}
- cdata_rd  input  DW  read data for caddr_rd
- cwr  output  1  write strobe to layer memory
- caddr_wr  output  12  write address = {2'b00, orow[4:0], ocol[4:0]}
- cdata_wr  output  DW  pooled value
- csel  output  3  memory select: RD_SEL when reading, WR_SEL when writing, 0 when idle

## Operation
- Reset (reset=0) clears all outputs immediately to 0: busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel. Output counters (orow, ocol) and the read phase also clear; FSM goes to IDLE.
- FSM states: IDLE, READ (2-bit phase counter p=0..3), WRITE.
- IDLE:
  - ready=1 at an edge sets busy=1, enters READ with p=0, orow=ocol=0.
  - Start is always at output 0; there is no resume.
- READ, phase p reads pixel (2*orow + p[1], 2*ocol + p[0]). Read order per window: top-left, top-right, bottom-left, bottom-right.
  - crd=1, csel=RD_SEL, cwr=0.
  - cdata_rd is sampled at the rising edge that ends the read cycle.
  - p=0: max register loads cdata_rd directly, with no compare against 0 (correct for negative inputs).
  - p=1..3: max <= (signed cdata_rd > signed max) ? cdata_rd : max. On a tie, max keeps its current value.
  - After p=3 the FSM goes to WRITE.
- WRITE, a single cycle:
  - cwr=1, crd=0, csel=WR_SEL, caddr_wr={2'b00,orow,ocol}, cdata_wr = final max, including the p=3 sample.
  - Then ocol increments. When ocol wraps 31->0, orow increments.
- Termination:
  - After the WRITE for orow=31, ocol=31 (caddr_wr=1023), the FSM returns to IDLE.
  - busy, cwr and crd drop to 0 at that same edge. caddr_wr and cdata_wr hold their last values.
- ready while busy=1 is ignored. If ready=1 in the first IDLE cycle after completion, a new pass starts.
- No arithmetic other than the signed compare. Output values are bit-exact copies of input words.
- Reset asserted mid-pass aborts immediately. Partial layer-1 contents are left as written. A new ready is required after reset releases.

## Timing
- Edge E0: ready=1 sampled in IDLE. The following cycle is cycle 1 (busy=1, crd=1, caddr_rd=0, csel=RD_SEL).
- Each output takes 5 cycles: 4 READ then 1 WRITE.
  - Output k has reads in cycles 5k+1..5k+4 and its write in cycle 5k+5.
- busy=1 for exactly 5120 cycles. The last write is in cycle 5120; busy=0 from cycle 5121.
- Memory contract: cdata_rd is valid within the same cycle in which caddr_rd/crd are presented (combinational read). The block registers it at the closing edge.
- crd and cwr are never both 1. csel changes only at cycle boundaries, together with the strobes.
- caddr_rd and caddr_wr are registered outputs, so there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold reset=0 mid-pass (cycle 2000) for 3 cycles -> all outputs read 0 while reset is asserted. After release, busy stays 0 until ready is pulsed.
- Ramp: L0[a]=a for a=0..4095 -> L1[k] = (2*orow+1)*64 + 2*ocol + 1. Check L1[0]=65, L1[1]=67, L1[32]=193, L1[1023]=4095. Read addresses for output 0 are 0, 1, 64, 65, in that order.
- Quadrant position: window 0 with the max 0x12345 placed in turn at TL, TR, BL and BR, all other pixels 0x00100 -> L1[0]=0x12345 each time.
- Negatives: window = {0xFFFFF, 0x80000, 0xFFFFE, 0x80001} -> L1[0]=0xFFFFF (-1), not 0. All-equal window 0x7FFFF -> 0x7FFFF.
- Handshake/latency:
  - ready pulsed 1 cycle -> busy rises at the next edge; first cwr in cycle 5 with caddr_wr=0; busy high exactly 5120 cycles; 1024 total cwr pulses.
  - ready held high throughout -> ignored while busy; second pass starts in cycle 5121.
- Protocol checker over a full pass:
  - crd&cwr never both 1.
  - csel=3'b001 whenever crd=1, csel=3'b011 whenever cwr=1.
  - Write addresses appear in order 0..1023 with no gaps or repeats.

Source files
------------

// File: rtl/conv_maxpool.sv
// ----------------------------------------------------------------------------
// conv_maxpool
//
// Second datapath stage of the CONV accelerator. Reads the 64x64 layer-0 map
// (20-bit signed Q4.16 words), applies 2x2 / stride-2 max-pooling and writes
// the 32x32 result into layer-1 memory. Shares the layer-memory port and the
// ready/busy start handshake with the convolution stage.
//
// Ports
//   clk       : clock, rising-edge active
//   reset     : asynchronous reset, active low
//   ready     : start request, sampled only while idle
//   busy      : high from start until the last write has completed
//   crd       : layer-memory read strobe
//   caddr_rd  : read address {row[5:0], col[5:0]}
//   cdata_rd  : read data (combinational memory, valid in the same cycle)
//   cwr       : layer-memory write strobe
//   caddr_wr  : write address {2'b00, orow[4:0], ocol[4:0]}
//   cdata_wr  : pooled value
//   csel      : memory select (RD_SEL reading, WR_SEL writing, 0 idle)
//
// State table
//   state | meaning
//   IDLE  | waiting for ready; strobes and csel low
//   READ  | reading one pixel of the current window, phase p = 0..3
//   WRITE | one-cycle write of the window maximum, then next window or IDLE
// ----------------------------------------------------------------------------
module conv_maxpool #(
    parameter int          DW     = 20,
    parameter logic [2:0]  RD_SEL = 3'b001,
    parameter logic [2:0]  WR_SEL = 3'b011
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          crd,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [11:0]   caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [1:0]    phase_q,    phase_d;
    logic [4:0]    orow_q,     orow_d;
    logic [4:0]    ocol_q,     ocol_d;
    logic [DW-1:0] max_q,      max_d;

    logic          busy_q,     busy_d;
    logic          crd_q,      crd_d;
    logic [11:0]   caddr_rd_q, caddr_rd_d;
    logic          cwr_q,      cwr_d;
    logic [11:0]   caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q,     csel_d;

    // Pixel (2*orow + p[1], 2*ocol + p[0]) of the window, read order TL, TR, BL, BR.
    function automatic logic [11:0] pix_addr(input logic [4:0] r,
                                             input logic [4:0] c,
                                             input logic [1:0] p);
        return {r, p[1], c, p[0]};
    endfunction

    logic          last_win;
    logic [DW-1:0] sample_max;

    assign last_win = (orow_q == 5'd31) && (ocol_q == 5'd31);

    // Phase 0 loads the first pixel unconditionally so an all-negative window
    // pools to its true maximum. Later phases replace only on strictly greater,
    // so ties keep the value already held.
    always_comb begin
        sample_max = max_q;
        if (phase_q == 2'd0) begin
            sample_max = cdata_rd;
        end else if ($signed(cdata_rd) > $signed(max_q)) begin
            sample_max = cdata_rd;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        max_d      = max_q;
        busy_d     = busy_q;
        crd_d      = crd_q;
        caddr_rd_d = caddr_rd_q;
        cwr_d      = cwr_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                crd_d  = 1'b0;
                cwr_d  = 1'b0;
                csel_d = 3'b000;
                if (ready) begin
                    state_d    = S_READ;
                    phase_d    = 2'd0;
                    orow_d     = 5'd0;
                    ocol_d     = 5'd0;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    caddr_rd_d = 12'd0;
                    csel_d     = RD_SEL;
                end
            end

            S_READ: begin
                max_d = sample_max;
                if (phase_q != 2'd3) begin
                    phase_d    = phase_q + 2'd1;
                    caddr_rd_d = pix_addr(orow_q, ocol_q, phase_q + 2'd1);
                end else begin
                    // The write word takes the p=3 sample directly, so no
                    // extra cycle is needed to settle the max register.
                    state_d    = S_WRITE;
                    phase_d    = 2'd0;
                    crd_d      = 1'b0;
                    cwr_d      = 1'b1;
                    csel_d     = WR_SEL;
                    caddr_wr_d = {2'b00, orow_q, ocol_q};
                    cdata_wr_d = sample_max;
                end
            end

            S_WRITE: begin
                cwr_d = 1'b0;
                if (last_win) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    crd_d   = 1'b0;
                    csel_d  = 3'b000;
                    orow_d  = 5'd0;
                    ocol_d  = 5'd0;
                end else begin
                    state_d = S_READ;
                    phase_d = 2'd0;
                    ocol_d  = ocol_q + 5'd1;
                    if (ocol_q == 5'd31) begin
                        orow_d = orow_q + 5'd1;
                    end
                    crd_d      = 1'b1;
                    csel_d     = RD_SEL;
                    caddr_rd_d = pix_addr(orow_d, ocol_d, 2'd0);
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                crd_d   = 1'b0;
                cwr_d   = 1'b0;
                csel_d  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 2'd0;
            orow_q     <= 5'd0;
            ocol_q     <= 5'd0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= 12'd0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= 12'd0;
            cdata_wr_q <= '0;
            csel_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// ----------------------------------------------------------------------------
// tb_conv_maxpool
//
// Bench for conv_maxpool. Layer-0 memory is a combinational array model,
// layer-1 memory captures writes. Expected window maxima are computed from
// the layer-0 contents and queued before each pass; every write strobe pops
// and compares address and data. Window-0 corner cases come from a table.
// ----------------------------------------------------------------------------
module tb_conv_maxpool;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          busy;
    logic          crd;
    logic [11:0]   caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [11:0]   caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    conv_maxpool #(.DW(DW), .RD_SEL(3'b001), .WR_SEL(3'b011)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] l0 [4096];
    logic [DW-1:0] l1 [1024];

    assign cdata_rd = l0[caddr_rd];

    always @(posedge clk) begin
        if (cwr) l1[caddr_wr[9:0]] <= cdata_wr;
    end

    typedef struct {
        logic [9:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string         name;
        logic [DW-1:0] tl, tr, bl, br;
        logic [DW-1:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] win_max(input int r, input int c);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] v;
        m = l0[(2 * r) * 64 + 2 * c];
        for (int q = 1; q < 4; q++) begin
            v = l0[(2 * r + q / 2) * 64 + 2 * c + q % 2];
            if (v > m) m = v;
        end
        return m;
    endfunction

    task automatic push_pass();
        exp_t e;
        for (int k = 0; k < 1024; k++) begin
            e.addr = k[9:0];
            e.data = win_max(k / 32, k % 32);
            sb.push_back(e);
        end
    endtask

    // Protocol and scoreboard monitor, sampling on the falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (crd || cwr) check("strobe_excl", {31'b0, crd & cwr}, 32'd0);
                if (crd) check("csel_rd", {29'b0, csel}, 32'd1);
                if (cwr) begin
                    check("csel_wr", {29'b0, csel}, 32'd3);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: unexpected write addr 0x%0h data 0x%0h", caddr_wr, cdata_wr);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", {20'b0, caddr_wr}, {22'b0, e.addr});
                        check("wr_data", {12'b0, cdata_wr}, {12'b0, e.data});
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_crd"},   {31'b0, crd},  32'd0);
        check({tag, "_cwr"},   {31'b0, cwr},  32'd0);
        check({tag, "_csel"},  {29'b0, csel}, 32'd0);
        check({tag, "_ardd"},  {20'b0, caddr_rd}, 32'd0);
        check({tag, "_awr"},   {20'b0, caddr_wr}, 32'd0);
        check({tag, "_dwr"},   {12'b0, cdata_wr}, 32'd0);
    endtask

    // Pulses ready, then counts busy cycles, write strobes and the cycle of
    // the first write; also logs the first four read addresses.
    task automatic run_pass(output int busy_cycles, output int first_wr,
                            output int n_wr, output logic [47:0] rdlog);
        busy_cycles = 0;
        first_wr    = -1;
        n_wr        = 0;
        rdlog       = '0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int c = 1; c <= 6000 && busy; c++) begin
            busy_cycles++;
            if (c <= 4) rdlog[(c-1)*12 +: 12] = caddr_rd;
            if (cwr) begin
                n_wr++;
                if (first_wr < 0) first_wr = c;
            end
            tick();
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL pass_timeout: busy still 1 after 6000 cycles, expected 0");
        end
    endtask

    vec_t vecs[8];

    initial begin
        int            bc;
        int            fw;
        int            nw;
        int            cnt;
        logic [47:0]   rl;

        vecs[0] = '{"quad_tl",  20'h12345, 20'h00100, 20'h00100, 20'h00100, 20'h12345};
        vecs[1] = '{"quad_tr",  20'h00100, 20'h12345, 20'h00100, 20'h00100, 20'h12345};
        vecs[2] = '{"quad_bl",  20'h00100, 20'h00100, 20'h12345, 20'h00100, 20'h12345};
        vecs[3] = '{"quad_br",  20'h00100, 20'h00100, 20'h00100, 20'h12345, 20'h12345};
        vecs[4] = '{"neg_mix",  20'hFFFFF, 20'h80000, 20'hFFFFE, 20'h80001, 20'hFFFFF};
        vecs[5] = '{"all_max",  20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
        vecs[6] = '{"all_min",  20'h80000, 20'h80000, 20'h80000, 20'h80000, 20'h80000};
        vecs[7] = '{"sign_bnd", 20'h00001, 20'h7FFFF, 20'h80000, 20'h7FFFE, 20'h7FFFF};

        reset = 1'b0;
        ready = 1'b0;
        for (int a = 0; a < 4096; a++) l0[a] = a[DW-1:0];
        fork
            monitor();
        join_none

        // Reset state, then idle without ready
        repeat (3) tick();
        check_all_zero("rst_init");
        reset = 1'b1;
        repeat (3) tick();
        check("idle_no_ready", {31'b0, busy}, 32'd0);

        // Ramp: full pass with latency, count and spot checks
        push_pass();
        run_pass(bc, fw, nw, rl);
        check("ramp_busy_cycles", bc, 32'd5120);
        check("ramp_first_wr",    fw, 32'd5);
        check("ramp_n_wr",        nw, 32'd1024);
        check("ramp_rd0", {20'b0, rl[11:0]},  32'd0);
        check("ramp_rd1", {20'b0, rl[23:12]}, 32'd1);
        check("ramp_rd2", {20'b0, rl[35:24]}, 32'd64);
        check("ramp_rd3", {20'b0, rl[47:36]}, 32'd65);
        check("ramp_l1_0",    {12'b0, l1[0]},    32'd65);
        check("ramp_l1_1",    {12'b0, l1[1]},    32'd67);
        check("ramp_l1_32",   {12'b0, l1[32]},   32'd193);
        check("ramp_l1_1023", {12'b0, l1[1023]}, 32'd4095);
        check("ramp_sb_drained", sb.size(), 32'd0);
        check("ramp_hold_awr", {20'b0, caddr_wr}, 32'd1023);

        // Window-0 corner cases: run to the first write, then abort by reset
        for (int a = 0; a < 4096; a++) l0[a] = 20'h00100;
        foreach (vecs[i]) begin
            exp_t e;
            l0[0]  = vecs[i].tl;
            l0[1]  = vecs[i].tr;
            l0[64] = vecs[i].bl;
            l0[65] = vecs[i].br;
            e.addr = 10'd0;
            e.data = vecs[i].exp;
            sb.push_back(e);
            ready = 1'b1;
            tick();
            ready = 1'b0;
            fw = -1;
            for (int c = 1; c <= 20; c++) begin
                if (cwr) begin
                    fw = c;
                    break;
                end
                tick();
            end
            check({vecs[i].name, "_wr_cycle"}, fw, 32'd5);
            check({vecs[i].name, "_data"}, {12'b0, cdata_wr}, {12'b0, vecs[i].exp});
            @(negedge clk);
            #1;
            reset = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            tick();
            check({vecs[i].name, "_sb_drained"}, sb.size(), 32'd0);
            sb.delete();
        end

        // Ready held high: back-to-back passes with a single idle cycle
        for (int a = 0; a < 4096; a++) l0[a] = a[DW-1:0];
        push_pass();
        push_pass();
        ready = 1'b1;
        tick();
        cnt = 0;
        for (int c = 1; c <= 6000 && busy; c++) begin
            cnt++;
            tick();
        end
        check("held_busy_cycles1", cnt, 32'd5120);
        check("held_gap_idle", {31'b0, busy}, 32'd0);
        tick();
        check("held_restart", {31'b0, busy}, 32'd1);
        check("held_restart_crd", {31'b0, crd}, 32'd1);
        ready = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 6000 && busy; c++) begin
            cnt++;
            tick();
        end
        check("held_busy_cycles2", cnt, 32'd5120);
        check("held_sb_drained", sb.size(), 32'd0);

        // Reset mid-pass at cycle 2000, held for 3 cycles
        push_pass();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (1999) tick();
        check("mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid0");
        tick();
        check_all_zero("rst_mid1");
        tick();
        check_all_zero("rst_mid2");
        reset = 1'b1;
        sb.delete();
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_busy", {31'b0, busy}, 32'd0);
            check("post_rst_crd",  {31'b0, crd},  32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
